// File: rtl/spi_pkg.sv
// spi_pkg: opcode constants, FSM state type and divider width shared
// by the SPI master and its half-period clock divider.
package spi_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam int DIV_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT_CMD,
    ST_GAP,
    ST_SHIFT_RD,
    ST_CS_HOLD
  } state_e;

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: counts CLK_DIV-cycle half-periods while enabled and
// flags which edge (rise or fall) each half-period boundary is.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_rise,
  output logic o_fall
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_hi;
  logic             w_tick;

  assign w_tick = i_en && (r_cnt == DIV_W'(CLK_DIV - 1));
  assign o_rise = w_tick && !r_hi;
  assign o_fall = w_tick && r_hi;

  // Phase restarts high: the first half-period acts as a masked
  // high half, so the one after it is always a low half.
  always_ff @(posedge clk) begin
    if (!rst_n || !i_en) begin
      r_cnt <= '0;
      r_hi  <= 1'b1;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_hi  <= !r_hi;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master for 10-bit command frames with a read
// phase on rd-data; define SPI_MASTER_DROP_CNT_EN to add drop_cnt.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned READ_GAP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] cmd,
  output logic       busy,
  output logic       done,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       SS_n,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO
`ifdef SPI_MASTER_DROP_CNT_EN
  ,
  output logic [7:0] drop_cnt
`endif
);

  state_e     r_state, w_nxt;
  logic [9:0] r_cmd;
  logic       r_rd;
  logic [7:0] r_cnt, r_rx, r_rd_data;
  logic       r_sclk, r_mosi, r_done, r_rd_valid;
  logic       w_rise, w_fall, w_en, w_accept;
  logic       w_shift, w_rd_op;

  assign w_en     = (r_state != ST_IDLE);
  assign w_accept = !w_en && start && !r_done;
  assign w_shift  = (r_state == ST_SHIFT_CMD) ||
                    (r_state == ST_GAP) ||
                    (r_state == ST_SHIFT_RD);

  assign busy     = w_en;
  assign SS_n     = !w_en;
  assign SCLK     = r_sclk;
  assign MOSI     = r_mosi;
  assign done     = r_done;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_en),
    .o_rise(w_rise),
    .o_fall(w_fall)
  );

  always_comb begin
    w_rd_op = 1'b0;
    unique case (cmd[9:8])
      OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR: w_rd_op = 1'b0;
      OP_RD_DATA: w_rd_op = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE:
        if (w_accept) w_nxt = ST_CS_SETUP;
      ST_CS_SETUP:
        if (w_fall) w_nxt = ST_SHIFT_CMD;
      ST_SHIFT_CMD:
        if (w_fall && r_cnt == 8'd9) begin
          if (!r_rd)              w_nxt = ST_CS_HOLD;
          else if (READ_GAP == 0) w_nxt = ST_SHIFT_RD;
          else                    w_nxt = ST_GAP;
        end
      ST_GAP:
        if (w_fall && r_cnt == 8'(READ_GAP - 1))
          w_nxt = ST_SHIFT_RD;
      ST_SHIFT_RD:
        if (w_fall && r_cnt == 8'd7) w_nxt = ST_CS_HOLD;
      ST_CS_HOLD:
        if (w_rise) w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  // r_cnt counts completed SCLK periods within the current state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cmd      <= '0;
      r_rd       <= 1'b0;
      r_cnt      <= '0;
      r_rx       <= '0;
      r_rd_data  <= '0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      if (w_nxt != r_state) r_cnt <= '0;
      else if (w_fall)      r_cnt <= r_cnt + 1'b1;
      if (w_shift && w_rise) r_sclk <= 1'b1;
      else if (w_fall)       r_sclk <= 1'b0;
      if (w_accept) begin
        r_cmd <= cmd;
        r_rd  <= w_rd_op;
      end
      if (r_state == ST_CS_SETUP && w_fall)
        r_mosi <= r_cmd[9];
      if (r_state == ST_SHIFT_CMD && w_fall) begin
        r_mosi <= r_cmd[8];
        r_cmd  <= {r_cmd[8:0], 1'b0};
      end
      if (r_state == ST_SHIFT_RD && w_rise)
        r_rx <= {r_rx[6:0], MISO};
      if (r_state == ST_CS_HOLD && w_rise) begin
        r_done     <= 1'b1;
        r_rd_valid <= r_rd;
        if (r_rd) r_rd_data <= r_rx;
      end
    end
  end

`ifdef SPI_MASTER_DROP_CNT_EN
  logic [7:0] r_drop;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_drop <= '0;
    else if (start && (w_en || r_done) && r_drop != 8'hFF)
      r_drop <= r_drop + 1'b1;
  end

  assign drop_cnt = r_drop;
`endif

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: two masters (CLK_DIV 2 and 1) checked every cycle
// against a frame-timeline model plus directed literal expectations.
module tb_spi_master;

  localparam int GAP = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [2] = '{1'b0, 1'b0};
  logic       start [2] = '{1'b0, 1'b0};
  logic       miso  [2] = '{1'b0, 1'b0};
  logic [9:0] cmd   [2] = '{10'h0, 10'h0};
  logic [7:0] sb    [2] = '{8'h0, 8'h0};
  logic       busy [2], done [2], rv [2];
  logic       ss_n [2], sclk [2], mosi [2];
  logic [7:0] rdd  [2];
`ifdef SPI_MASTER_DROP_CNT_EN
  logic [7:0] dcnt [2];
`endif

  spi_master #(.CLK_DIV(2), .READ_GAP(GAP)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .cmd(cmd[0]),
    .busy(busy[0]), .done(done[0]), .rd_valid(rv[0]),
    .rd_data(rdd[0]), .SS_n(ss_n[0]), .SCLK(sclk[0]),
    .MOSI(mosi[0]), .MISO(miso[0])
`ifdef SPI_MASTER_DROP_CNT_EN
    , .drop_cnt(dcnt[0])
`endif
  );

  spi_master #(.CLK_DIV(1), .READ_GAP(GAP)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .cmd(cmd[1]),
    .busy(busy[1]), .done(done[1]), .rd_valid(rv[1]),
    .rd_data(rdd[1]), .SS_n(ss_n[1]), .SCLK(sclk[1]),
    .MOSI(mosi[1]), .MISO(miso[1])
`ifdef SPI_MASTER_DROP_CNT_EN
    , .drop_cnt(dcnt[1])
`endif
  );

  int errs = 0;
  int checks = 0;

  function automatic int div_of(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic chk(string name, int i, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s inst%0d @%0t: got %0h expected %0h",
               name, i, $time, act, exp);
    end
  endtask

  // Model: one frame = setup + nper SCLK periods + hold, each
  // half-period d cycles; t counts cycles since SS_n went low.
  bit         m_act  [2] = '{0, 0};
  bit         m_done [2] = '{0, 0};
  bit         m_rv   [2] = '{0, 0};
  int         m_t    [2] = '{0, 0};
  int         m_len  [2] = '{0, 0};
  int         m_drop [2] = '{0, 0};
  logic [9:0] m_cmd  [2] = '{10'h0, 10'h0};
  logic [7:0] m_byte [2] = '{8'h0, 8'h0};
  logic [7:0] m_rdd  [2] = '{8'h0, 8'h0};

  function automatic int nper_of(logic [9:0] c);
    return 10 + ((c[9:8] == 2'b11) ? GAP + 8 : 0);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) begin
        m_act[i] = 0; m_done[i] = 0; m_rv[i] = 0;
        m_rdd[i] = 8'h0; m_drop[i] = 0;
      end else if (m_act[i]) begin
        m_done[i] = 0; m_rv[i] = 0;
        if (start[i] && m_drop[i] < 255) m_drop[i]++;
        if (m_t[i] + 1 == m_len[i]) begin
          m_act[i] = 0;
          m_done[i] = 1;
          if (m_cmd[i][9:8] == 2'b11) begin
            m_rv[i] = 1;
            m_rdd[i] = m_byte[i];
          end
        end else begin
          m_t[i]++;
        end
      end else begin
        if (start[i] && !m_done[i]) begin
          m_act[i] = 1; m_t[i] = 0;
          m_cmd[i] = cmd[i]; m_byte[i] = sb[i];
          m_len[i] = 2 * div_of(i) * nper_of(cmd[i]) + 2 * div_of(i);
        end else if (start[i] && m_drop[i] < 255) begin
          m_drop[i]++;
        end
        m_done[i] = 0; m_rv[i] = 0;
      end
    end
  end

  int         low_cnt [2] = '{0, 0};
  int         hi_cnt  [2] = '{0, 0};
  int         last_len[2] = '{0, 0};
  int         last_gap[2] = '{0, 0};
  int         done_cnt[2] = '{0, 0};
  int         nrise   [2] = '{0, 0};
  logic [9:0] bits    [2] = '{10'h0, 10'h0};
  logic [9:0] last_bits[2] = '{10'h0, 10'h0};
  logic       p_ss    [2] = '{1'b1, 1'b1};
  logic       p_sclk  [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin : cmp
    int d, nper, u, p;
    logic e_ss, e_sclk, e_mosi, c_mosi, e_done, e_rv;
    for (int i = 0; i < 2; i++) begin
      d = div_of(i);
      p = -1;
      nper = nper_of(m_cmd[i]);
      e_sclk = 1'b0; e_mosi = 1'b0; c_mosi = 1'b1;
      if (m_act[i]) begin
        e_ss = 1'b0; e_done = 1'b0; e_rv = 1'b0; c_mosi = 1'b0;
        if (m_t[i] >= d) begin
          u = m_t[i] - d;
          p = u / (2 * d);
          if (p < nper) begin
            e_sclk = ((u % (2 * d)) >= d);
            c_mosi = 1'b1;
            e_mosi = (p < 10) ? m_cmd[i][9-p] : 1'b0;
          end
        end
      end else begin
        e_ss = 1'b1; e_done = m_done[i]; e_rv = m_rv[i];
      end
      chk("SS_n", i, ss_n[i], e_ss);
      chk("busy", i, busy[i], !e_ss);
      chk("SCLK", i, sclk[i], e_sclk);
      chk("done", i, done[i], e_done);
      chk("rd_valid", i, rv[i], e_rv);
      chk("rd_data", i, rdd[i], m_rdd[i]);
      if (c_mosi) chk("MOSI", i, mosi[i], e_mosi);
`ifdef SPI_MASTER_DROP_CNT_EN
      chk("drop_cnt", i, dcnt[i], m_drop[i]);
`endif
      if (m_act[i] && m_cmd[i][9:8] == 2'b11 &&
          p >= 10 + GAP && p < nper)
        miso[i] = m_byte[i][7-(p-10-GAP)];
      else
        miso[i] = 1'($urandom);
      if (p_ss[i] && !ss_n[i]) begin
        last_gap[i] = hi_cnt[i];
        low_cnt[i] = 0; nrise[i] = 0; bits[i] = 10'h0;
      end
      if (!p_ss[i] && ss_n[i]) begin
        last_len[i] = low_cnt[i];
        last_bits[i] = bits[i];
      end
      if (ss_n[i]) hi_cnt[i]++;
      else begin
        hi_cnt[i] = 0;
        low_cnt[i]++;
      end
      if (!ss_n[i] && sclk[i] && !p_sclk[i] && nrise[i] < 10) begin
        bits[i] = {bits[i][8:0], mosi[i]};
        nrise[i]++;
      end
      if (done[i]) done_cnt[i]++;
      p_ss[i] = ss_n[i];
      p_sclk[i] = sclk[i];
    end
  end

  task automatic wait_done(input int i, input int lim,
                           output logic v, output logic [7:0] d);
    int n;
    n = 0;
    while (!done[i] && n < lim) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done[i]) begin
      errs++;
      $display("FAIL timeout inst%0d: done not seen in %0d cycles",
               i, lim);
    end
    v = rv[i];
    d = rdd[i];
    @(negedge clk);
  endtask

  task automatic frame(input int i, input logic [9:0] c,
                       input logic [7:0] b,
                       output logic v, output logic [7:0] d);
    @(negedge clk);
    sb[i] = b; cmd[i] = c; start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    wait_done(i, 400, v, d);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic v;
    logic [7:0] d;
    int dc, n;

    repeat (3) @(negedge clk);
    chk("rst_SS_n", 0, ss_n[0], 1);
    chk("rst_SCLK", 0, sclk[0], 0);
    chk("rst_MOSI", 0, mosi[0], 0);
    chk("rst_rd_data", 1, rdd[1], 8'h00);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    repeat (2) @(negedge clk);

    frame(0, 10'h0A5, 8'h00, v, d);
    chk("wr_len", 0, last_len[0], 44);
    chk("wr_bits", 0, last_bits[0], 10'h0A5);
    chk("wr_rv", 0, v, 0);

    frame(0, 10'h300, 8'h3C, v, d);
    chk("rd_len", 0, last_len[0], 80);
    chk("rd_valid_at_done", 0, v, 1);
    chk("rd_byte", 0, d, 8'h3C);

    frame(1, 10'h3C5, 8'hA5, v, d);
    chk("div1_len", 1, last_len[1], 40);
    chk("div1_rv", 1, v, 1);
    chk("div1_byte", 1, d, 8'hA5);

    dc = done_cnt[0];
    @(negedge clk);
    cmd[0] = 10'h1C3; start[0] = 1'b1;
    repeat (150) @(negedge clk);
    start[0] = 1'b0;
    repeat (60) @(negedge clk);
    chk("b2b_gap", 0, last_gap[0], 2);
    chk("b2b_frames", 0, (done_cnt[0] - dc) >= 3, 1);

    @(negedge clk);
    cmd[0] = 10'h155; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n = 0;
    while (!(m_act[0] && m_t[0] == 22) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_bit5", 0, m_act[0] && m_t[0] == 22, 1);
    dc = done_cnt[0];
    rst_n[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_SS_n", 0, ss_n[0], 1);
    chk("abort_SCLK", 0, sclk[0], 0);
    rst_n[0] = 1'b1;
    repeat (60) @(negedge clk);
    chk("abort_no_done", 0, done_cnt[0], dc);
    frame(0, 10'h0A5, 8'h00, v, d);
    chk("after_abort_len", 0, last_len[0], 44);
    chk("after_abort_done", 0, done_cnt[0], dc + 1);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        start[i] = ($urandom_range(0, 5) == 0);
        cmd[i]   = 10'($urandom);
        sb[i]    = 8'($urandom);
        rst_n[i] = ($urandom_range(0, 799) != 0);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      rst_n[i] = 1'b1;
    end
    repeat (100) @(negedge clk);

`ifdef SPI_MASTER_DROP_CNT_EN
    rst_n[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    cmd[0] = 10'h3FF; start[0] = 1'b1;
    repeat (400) @(negedge clk);
    start[0] = 1'b0;
    repeat (100) @(negedge clk);
    chk("drop_sat", 0, dcnt[0], 8'd255);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning clk cycles per SCLK half-period (legal range 1..255).
REQ-002 SHALL have parameter READ_GAP, default 1, meaning the number of SCLK periods between the last command bit and the first MISO bit on a read.
REQ-003 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  in  1  request strobe; accepted only when busy=0.
REQ-006 SHALL have port cmd  in  10  frame: [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload.
REQ-007 SHALL have port busy  out  1  high from the accept cycle until done.
REQ-008 SHALL have port done  out  1  one-cycle pulse at frame end.
REQ-009 SHALL have port rd_valid  out  1  one-cycle pulse coincident with done on opcode 11 frames only.
REQ-010 SHALL have port rd_data  out  8  byte received on the last opcode 11 frame.
REQ-011 SHALL have port SS_n  out  1  active-low slave select.
REQ-012 SHALL have port SCLK  out  1  serial clock, idle low (mode 0).
REQ-013 SHALL have port MOSI  out  1  serial data to slave.
REQ-014 SHALL have port MISO  in  1  serial data from slave.

Function
REQ-015 SHALL latch cmd on the cycle start=1 while in IDLE; SS_n low and busy high from the next cycle.
REQ-016 SHALL implement FSM IDLE -> CS_SETUP -> SHIFT_CMD -> (GAP -> SHIFT_RD if opcode 11) -> CS_HOLD -> IDLE.
REQ-017 CS_SETUP and CS_HOLD SHALL each last CLK_DIV cycles with SCLK low.
REQ-018 Each SCLK period SHALL be CLK_DIV cycles low then CLK_DIV cycles high.
REQ-019 SHIFT_CMD SHALL send 10 bits, MSB (cmd[9]) first, with MOSI updated at the start of each low phase.
REQ-020 GAP SHALL clock READ_GAP periods with MOSI=0.
REQ-021 SHIFT_RD SHALL clock 8 periods with MOSI=0, sampling MISO on the cycle SCLK rises, MSB first.
REQ-022 SHALL raise SS_n, pulse done, and drop busy on the cycle IDLE is re-entered.
REQ-023 rd_data SHALL update only with rd_valid and hold otherwise.
REQ-024 start while busy=1 SHALL be ignored; start on the same cycle as done SHALL be ignored; start is accepted from the following cycle.
REQ-025 MOSI SHALL be 0 whenever SS_n=1.

Reset
REQ-026 rst_n=0 SHALL force IDLE with SS_n=1, SCLK=0, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=0, including mid-frame (the frame is aborted and no done pulse is issued).

Configuration
REQ-027 With SPI_MASTER_DROP_CNT_EN defined, the block SHALL add output drop_cnt[7:0]: an 8-bit count of start pulses ignored under REQ-024, saturating at 255 and reset to 0.
REQ-028 Without SPI_MASTER_DROP_CNT_EN, the drop_cnt port and its logic SHALL be absent.

Structure
REQ-029 Opcode constants (OP_WR_ADDR..OP_RD_DATA) and the FSM state typedef SHALL reside in shared package spi_pkg.
REQ-030 The SCLK half-period divider SHALL be sub-module spi_clk_div (enable in; rise/fall tick outputs).

Verification
REQ-031 CLK_DIV=2, cmd=10'h0A5 (wr-addr) -> SS_n low for 44 cycles, MOSI bits 00_1010_0101, done once, rd_valid=0.
REQ-032 CLK_DIV=2, READ_GAP=1, cmd=10'h300, slave model drives 8'h3C -> SS_n low for 80 cycles, rd_data=8'h3C with rd_valid and done.
REQ-033 Back-to-back frames: start held high continuously -> second frame begins the cycle after done, with no overlap of SS_n low periods.
REQ-034 Assert rst_n=0 at SHIFT_CMD bit 5 -> SS_n=1, SCLK=0, and no done pulse; a new frame then completes normally.
REQ-035 With SPI_MASTER_DROP_CNT_EN defined, 300 starts while busy -> drop_cnt=255.
REQ-036 CLK_DIV=1 read frame -> SCLK toggles every cycle and MISO is sampled correctly (rd_data matches the slave model).
